// File: rtl/uiarp_pkg.sv
// Shared ARP constants, frame layout and tx FSM encoding.
// Also imported by the ARP rx parser and the MAC cache.
package uiarp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IP   = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'h06;
  localparam logic [7:0]  ARP_PLEN       = 8'h04;
  localparam logic [15:0] ARP_REQUEST    = 16'h0001;
  localparam logic [15:0] ARP_REPLY      = 16'h0002;
  localparam logic [47:0] MAC_BROADCAST  = 48'hFFFF_FFFF_FFFF;
  localparam int          ARP_BODY_BYTES = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arp_tx_state_e;

  typedef struct packed {
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_frame_t;

  // Full 28-byte ARP body, byte 0 in the top bits.
  function automatic logic [223:0] arp_body(input arp_frame_t f);
    return {ARP_HTYPE_ETH, ARP_PTYPE_IP, ARP_HLEN, ARP_PLEN,
            f.oper, f.sha, f.spa, f.tha, f.tpa};
  endfunction

endpackage

// File: rtl/uiarp_tx_bytesel.sv
// Picks one byte of the latched ARP frame by index; indices past the
// ARP body return the zero padding.
module uiarp_tx_bytesel
  import uiarp_pkg::*;
(
  input  arp_frame_t  frame,
  input  logic [5:0]  byte_idx,
  output logic [7:0]  byte_data
);

  logic [223:0] body;
  logic [4:0]   rev_idx;

  always_comb begin
    body      = arp_body(frame);
    rev_idx   = '0;
    byte_data = 8'h00;
    if (byte_idx < 6'(ARP_BODY_BYTES)) begin
      rev_idx   = 5'(6'(ARP_BODY_BYTES - 1) - byte_idx);
      byte_data = body[{rev_idx, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/uiarp_tx.sv
// ARP transmit stage: holds one pending reply and one pending request and
// serialises them as padded ARP frames toward the MAC TX arbiter.
module uiarp_tx
  import uiarp_pkg::*;
#(
  parameter int MIN_PAYLOAD = 46,   // 28..63
  parameter int IFG_CYCLES  = 12
) (
  input  logic          I_arp_clk,
  input  logic          I_arp_reset_n,
  input  logic [31:0]   I_ip_local_addr,
  input  logic [47:0]   I_mac_local_addr,
  input  logic          I_arp_req_valid,
  input  logic [31:0]   I_arp_req_ip_addr,
  input  logic [47:0]   I_arp_req_mac_addr,
  input  logic          I_arp_query_valid,
  input  logic [31:0]   I_arp_query_ip_addr,
  input  logic          I_arp_tready,
  output logic          O_arp_tvalid,
  output logic [7:0]    O_arp_tdata,
  output logic          O_arp_tlast,
  output logic [47:0]   O_arp_tdest_mac,
  output logic          O_arp_busy,
  output logic          O_arp_reply_sent,
  output logic          O_arp_request_sent,
  output arp_tx_state_e O_arp_state
);

  localparam logic [5:0] LAST_IDX = 6'(MIN_PAYLOAD - 1);
  localparam int         GW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  arp_tx_state_e state_q, state_d;

  logic          rply_pend_q;
  logic [31:0]   rply_ip_q;
  logic [47:0]   rply_mac_q;
  logic          qry_pend_q;
  logic [31:0]   qry_ip_q;

  arp_frame_t    frame_q;
  logic [47:0]   dest_q;
  logic          is_reply_q;
  logic [5:0]    byte_cnt_q;
  logic [GW-1:0] gap_cnt_q;

  logic          take_reply, take_query;
  logic          beat, last_beat;
  logic [7:0]    sel_data;

  // Handshake: a byte moves when tvalid & tready at a rising edge; while
  // tready is low, tvalid/tdata/tlast/tdest hold their values.
  always_comb begin
    state_d    = state_q;
    take_reply = 1'b0;
    take_query = 1'b0;
    beat       = (state_q == SEND) && I_arp_tready;
    last_beat  = beat && (byte_cnt_q == LAST_IDX);
    case (state_q)
      IDLE: begin
        if (rply_pend_q) begin
          take_reply = 1'b1;
          state_d    = SEND;
        end else if (qry_pend_q) begin
          take_query = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (last_beat) state_d = (IFG_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_arp_clk or negedge I_arp_reset_n) begin
    if (!I_arp_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // A pulse in the same cycle its slot is consumed re-arms the slot.
  always_ff @(posedge I_arp_clk or negedge I_arp_reset_n) begin
    if (!I_arp_reset_n) begin
      rply_pend_q <= 1'b0;
      rply_ip_q   <= '0;
      rply_mac_q  <= '0;
      qry_pend_q  <= 1'b0;
      qry_ip_q    <= '0;
    end else begin
      if (take_reply) rply_pend_q <= 1'b0;
      if (take_query) qry_pend_q  <= 1'b0;
      if (I_arp_req_valid) begin
        rply_pend_q <= 1'b1;
        rply_ip_q   <= I_arp_req_ip_addr;
        rply_mac_q  <= I_arp_req_mac_addr;
      end
      if (I_arp_query_valid) begin
        qry_pend_q <= 1'b1;
        qry_ip_q   <= I_arp_query_ip_addr;
      end
    end
  end

  always_ff @(posedge I_arp_clk or negedge I_arp_reset_n) begin
    if (!I_arp_reset_n) begin
      frame_q    <= '0;
      dest_q     <= '0;
      is_reply_q <= 1'b0;
    end else if (take_reply) begin
      frame_q.oper <= ARP_REPLY;
      frame_q.sha  <= I_mac_local_addr;
      frame_q.spa  <= I_ip_local_addr;
      frame_q.tha  <= rply_mac_q;
      frame_q.tpa  <= rply_ip_q;
      dest_q       <= rply_mac_q;
      is_reply_q   <= 1'b1;
    end else if (take_query) begin
      frame_q.oper <= ARP_REQUEST;
      frame_q.sha  <= I_mac_local_addr;
      frame_q.spa  <= I_ip_local_addr;
      frame_q.tha  <= '0;
      frame_q.tpa  <= qry_ip_q;
      dest_q       <= MAC_BROADCAST;
      is_reply_q   <= 1'b0;
    end
  end

  always_ff @(posedge I_arp_clk or negedge I_arp_reset_n) begin
    if (!I_arp_reset_n) begin
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      if (take_reply || take_query) byte_cnt_q <= '0;
      else if (beat)                byte_cnt_q <= last_beat ? 6'd0 : byte_cnt_q + 6'd1;
      if (last_beat)               gap_cnt_q <= '0;
      else if (state_q == GAP)     gap_cnt_q <= gap_cnt_q + GW'(1);
    end
  end

  uiarp_tx_bytesel u_bytesel (
    .frame     (frame_q),
    .byte_idx  (byte_cnt_q),
    .byte_data (sel_data)
  );

  assign O_arp_tvalid       = (state_q == SEND);
  assign O_arp_tdata        = O_arp_tvalid ? sel_data : 8'h00;
  assign O_arp_tlast        = O_arp_tvalid && (byte_cnt_q == LAST_IDX);
  assign O_arp_tdest_mac    = dest_q;
  assign O_arp_busy         = (state_q != IDLE);
  assign O_arp_reply_sent   = last_beat && is_reply_q;
  assign O_arp_request_sent = last_beat && !is_reply_q;
  assign O_arp_state        = state_q;

endmodule

// File: tb/tb_uiarp_tx.sv
// Directed bench for uiarp_tx: reply/request framing, priority, gap,
// backpressure, slot overwrite and mid-frame reset.
module tb_uiarp_tx;
  import uiarp_pkg::*;

  localparam int MIN_PAYLOAD = 46;
  localparam int IFG_CYCLES  = 12;

  localparam logic [31:0] LOCAL_IP  = 32'hC0A8_010A;
  localparam logic [47:0] LOCAL_MAC = 48'h000A_3501_0203;
  localparam logic [31:0] REQ_IP    = 32'hC0A8_0164;
  localparam logic [31:0] REQ_IP2   = 32'hC0A8_0165;
  localparam logic [47:0] REQ_MAC   = 48'h1122_3344_5566;
  localparam logic [31:0] QRY_IP    = 32'hC0A8_0101;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   ip_local;
  logic [47:0]   mac_local;
  logic          req_valid;
  logic [31:0]   req_ip;
  logic [47:0]   req_mac;
  logic          qry_valid;
  logic [31:0]   qry_ip;
  logic          tready;
  logic          tvalid;
  logic [7:0]    tdata;
  logic          tlast;
  logic [47:0]   tdest;
  logic          busy;
  logic          reply_sent;
  logic          request_sent;
  arp_tx_state_e dbg_state;

  always #5 clk = ~clk;

  uiarp_tx #(.MIN_PAYLOAD(MIN_PAYLOAD), .IFG_CYCLES(IFG_CYCLES)) dut (
    .I_arp_clk           (clk),
    .I_arp_reset_n       (rst_n),
    .I_ip_local_addr     (ip_local),
    .I_mac_local_addr    (mac_local),
    .I_arp_req_valid     (req_valid),
    .I_arp_req_ip_addr   (req_ip),
    .I_arp_req_mac_addr  (req_mac),
    .I_arp_query_valid   (qry_valid),
    .I_arp_query_ip_addr (qry_ip),
    .I_arp_tready        (tready),
    .O_arp_tvalid        (tvalid),
    .O_arp_tdata         (tdata),
    .O_arp_tlast         (tlast),
    .O_arp_tdest_mac     (tdest),
    .O_arp_busy          (busy),
    .O_arp_reply_sent    (reply_sent),
    .O_arp_request_sent  (request_sent),
    .O_arp_state         (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [47:0] got_dest;
  int          got_last_idx, first_valid, n_reply_pulse, n_req_pulse;
  int          stab_err, dest_err;
  bit          timed_out;
  logic [31:0] pulse_ip;
  logic [47:0] pulse_mac;

  // Reply frame from the datasheet example, before padding.
  logic [7:0] reply_ref [0:27] = '{
    8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02,
    8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03, 8'hC0, 8'hA8, 8'h01, 8'h0A,
    8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hC0, 8'hA8, 8'h01, 8'h64};

  task automatic build_exp(input logic [15:0] oper, input logic [47:0] sha,
                           input logic [31:0] spa, input logic [47:0] tha,
                           input logic [31:0] tpa);
    exp_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    exp_q.push_back(8'h08); exp_q.push_back(8'h00);
    exp_q.push_back(8'h06); exp_q.push_back(8'h04);
    exp_q.push_back(oper[15:8]); exp_q.push_back(oper[7:0]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(sha[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(spa[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(tha[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(tpa[i*8 +: 8]);
    while (exp_q.size() < MIN_PAYLOAD) exp_q.push_back(8'h00);
  endtask

  task automatic build_reply_ref();
    exp_q.delete();
    for (int i = 0; i < 28; i++) exp_q.push_back(reply_ref[i]);
    while (exp_q.size() < MIN_PAYLOAD) exp_q.push_back(8'h00);
  endtask

  // -1 when got_q matches exp_q, -2 on a length difference, else first bad index.
  function automatic int first_bad();
    if (got_q.size() != exp_q.size()) return -2;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    return (i >= 0 && i < got_q.size()) ? got_q[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'hxx;
  endfunction

  // Called on a negedge; returns on the negedge after the tlast handshake.
  task automatic collect_frame(input bit rnd, input int pulse_at);
    logic       prev_stall;
    logic [7:0] prev_data;
    bit         done_now;
    got_q.delete();
    got_last_idx = -1; first_valid = -1; n_reply_pulse = 0; n_req_pulse = 0;
    stab_err = 0; dest_err = 0; timed_out = 1'b1;
    prev_stall = 1'b0; prev_data = 8'h00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == pulse_at) begin
        req_valid = 1'b1; req_ip = pulse_ip; req_mac = pulse_mac;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (prev_stall && (tvalid !== 1'b1 || tdata !== prev_data)) stab_err++;
      if (tvalid === 1'b1) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          got_dest    = tdest;
        end else if (tdest !== got_dest) begin
          dest_err++;
        end
      end
      if (reply_sent === 1'b1)   n_reply_pulse++;
      if (request_sent === 1'b1) n_req_pulse++;
      prev_stall = (tvalid === 1'b1) && !tready;
      prev_data  = tdata;
      done_now   = (tvalid === 1'b1) && tready && (tlast === 1'b1);
      if (tvalid === 1'b1 && tready) got_q.push_back(tdata);
      if (done_now) got_last_idx = got_q.size() - 1;
      @(negedge clk);
      if (done_now) begin
        timed_out = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
    tready    = 1'b1;
  endtask

  task automatic pulse_req(input logic [31:0] ip, input logic [47:0] mac);
    req_valid = 1'b1; req_ip = ip; req_mac = mac;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    n_checks++;
    if (cyc >= 200) $display("FAIL wait_idle: busy still %b after %0d cycles, want 0", busy, cyc);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 8'h00) $display("FAIL reset_stream: tvalid %b tlast %b tdata %h, want 0 0 00", tvalid, tlast, tdata);
    else n_pass++;
    n_checks++;
    if (tdest !== 48'h0) $display("FAIL reset_tdest: got %h want 0", tdest);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || reply_sent !== 1'b0 || request_sent !== 1'b0) $display("FAIL reset_status: busy %b reply %b request %b, want 0 0 0", busy, reply_sent, request_sent);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dbg_state !== IDLE || tvalid !== 1'b0) $display("FAIL post_reset_idle: state %0d tvalid %b, want 0 0", dbg_state, tvalid);
    else n_pass++;
  endtask

  task automatic test_reply();
    int bad;
    pulse_req(REQ_IP, REQ_MAC);
    collect_frame(1'b0, -1);
    build_reply_ref();
    n_checks++;
    if (timed_out) $display("FAIL reply_timeout: no tlast handshake, got %0d bytes want %0d", got_q.size(), MIN_PAYLOAD);
    else n_pass++;
    n_checks++;
    if (first_valid !== 1) $display("FAIL reply_latency: first valid at cycle %0d want 1", first_valid);
    else n_pass++;
    bad = first_bad();
    n_checks++;
    if (bad != -1) $display("FAIL reply_bytes: index %0d got %h want %h (len %0d want %0d)", bad, got_at(bad), exp_at(bad), got_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (got_dest !== REQ_MAC || dest_err != 0) $display("FAIL reply_tdest: got %h (changes %0d) want %h", got_dest, dest_err, REQ_MAC);
    else n_pass++;
    n_checks++;
    if (got_last_idx != MIN_PAYLOAD - 1) $display("FAIL reply_tlast: tlast at byte %0d want %0d", got_last_idx, MIN_PAYLOAD - 1);
    else n_pass++;
    n_checks++;
    if (n_reply_pulse != 1 || n_req_pulse != 0) $display("FAIL reply_pulses: reply %0d request %0d, want 1 0", n_reply_pulse, n_req_pulse);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1 || tvalid !== 1'b0) $display("FAIL reply_gap: busy %b tvalid %b, want 1 0", busy, tvalid);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_query();
    int bad;
    qry_valid = 1'b1; qry_ip = QRY_IP;
    @(negedge clk);
    qry_valid = 1'b0;
    collect_frame(1'b0, -1);
    build_exp(16'h0001, LOCAL_MAC, LOCAL_IP, 48'h0, QRY_IP);
    n_checks++;
    if (timed_out || first_valid !== 1) $display("FAIL query_start: timeout %0d first valid %0d want 0 1", timed_out, first_valid);
    else n_pass++;
    bad = first_bad();
    n_checks++;
    if (bad != -1) $display("FAIL query_bytes: index %0d got %h want %h (len %0d want %0d)", bad, got_at(bad), exp_at(bad), got_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (got_dest !== 48'hFFFF_FFFF_FFFF) $display("FAIL query_tdest: got %h want ffffffffffff", got_dest);
    else n_pass++;
    n_checks++;
    if (n_req_pulse != 1 || n_reply_pulse != 0) $display("FAIL query_pulses: request %0d reply %0d, want 1 0", n_req_pulse, n_reply_pulse);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int bad;
    req_valid = 1'b1; req_ip = REQ_IP; req_mac = REQ_MAC;
    qry_valid = 1'b1; qry_ip = QRY_IP;
    @(negedge clk);
    req_valid = 1'b0; qry_valid = 1'b0;
    collect_frame(1'b0, -1);
    build_reply_ref();
    bad = first_bad();
    n_checks++;
    if (timed_out || bad != -1) $display("FAIL b2b_first_reply: timeout %0d index %0d got %h want %h", timed_out, bad, got_at(bad), exp_at(bad));
    else n_pass++;
    n_checks++;
    if (n_reply_pulse != 1 || n_req_pulse != 0) $display("FAIL b2b_first_pulses: reply %0d request %0d, want 1 0", n_reply_pulse, n_req_pulse);
    else n_pass++;
    collect_frame(1'b0, -1);
    build_exp(16'h0001, LOCAL_MAC, LOCAL_IP, 48'h0, QRY_IP);
    n_checks++;
    if (first_valid != IFG_CYCLES + 1) $display("FAIL b2b_gap: second frame after %0d cycles want %0d", first_valid, IFG_CYCLES + 1);
    else n_pass++;
    bad = first_bad();
    n_checks++;
    if (timed_out || bad != -1) $display("FAIL b2b_second_request: timeout %0d index %0d got %h want %h", timed_out, bad, got_at(bad), exp_at(bad));
    else n_pass++;
    n_checks++;
    if (n_req_pulse != 1 || got_dest !== MAC_BROADCAST) $display("FAIL b2b_second_meta: request %0d tdest %h, want 1 ffffffffffff", n_req_pulse, got_dest);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_random_ready();
    int bad;
    pulse_req(REQ_IP, REQ_MAC);
    @(negedge clk);
    // Frame is latched by now; these must not reach the wire.
    ip_local = 32'hDEAD_BEEF; mac_local = 48'hAABB_CCDD_EEFF;
    collect_frame(1'b1, -1);
    ip_local = LOCAL_IP; mac_local = LOCAL_MAC;
    build_reply_ref();
    bad = first_bad();
    n_checks++;
    if (timed_out || bad != -1) $display("FAIL random_ready_bytes: timeout %0d index %0d got %h want %h", timed_out, bad, got_at(bad), exp_at(bad));
    else n_pass++;
    n_checks++;
    if (stab_err != 0) $display("FAIL random_ready_stable: %0d unstable stall cycles, want 0", stab_err);
    else n_pass++;
    n_checks++;
    if (dest_err != 0 || got_dest !== REQ_MAC) $display("FAIL random_ready_tdest: got %h changes %0d, want %h 0", got_dest, dest_err, REQ_MAC);
    else n_pass++;
    n_checks++;
    if (n_reply_pulse != 1) $display("FAIL random_ready_pulse: reply %0d want 1", n_reply_pulse);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_set_priority();
    int bad;
    req_valid = 1'b1; req_ip = REQ_IP; req_mac = REQ_MAC;
    @(negedge clk);
    req_ip = REQ_IP2;
    @(negedge clk);
    req_valid = 1'b0;
    collect_frame(1'b0, -1);
    build_reply_ref();
    bad = first_bad();
    n_checks++;
    if (timed_out || first_valid != 0 || bad != -1) $display("FAIL setprio_first: timeout %0d first valid %0d index %0d got %h want %h", timed_out, first_valid, bad, got_at(bad), exp_at(bad));
    else n_pass++;
    collect_frame(1'b0, -1);
    build_exp(16'h0002, LOCAL_MAC, LOCAL_IP, REQ_MAC, REQ_IP2);
    bad = first_bad();
    n_checks++;
    if (timed_out || bad != -1) $display("FAIL setprio_second: timeout %0d index %0d got %h want %h", timed_out, bad, got_at(bad), exp_at(bad));
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_overwrite();
    int bad, extra;
    pulse_req(REQ_IP, REQ_MAC);
    pulse_ip = REQ_IP2; pulse_mac = REQ_MAC;
    collect_frame(1'b0, 10);
    build_reply_ref();
    bad = first_bad();
    n_checks++;
    if (timed_out || bad != -1) $display("FAIL overwrite_current: timeout %0d index %0d got %h want %h", timed_out, bad, got_at(bad), exp_at(bad));
    else n_pass++;
    collect_frame(1'b0, -1);
    build_exp(16'h0002, LOCAL_MAC, LOCAL_IP, REQ_MAC, REQ_IP2);
    bad = first_bad();
    n_checks++;
    if (timed_out || bad != -1) $display("FAIL overwrite_next: timeout %0d index %0d got %h want %h", timed_out, bad, got_at(bad), exp_at(bad));
    else n_pass++;
    wait_idle();
    extra = 0;
    repeat (120) begin
      @(negedge clk);
      if (tvalid === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) $display("FAIL overwrite_frame_count: %0d extra valid cycles, want 0", extra);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int cyc, extra;
    req_valid = 1'b1; req_ip = REQ_IP; req_mac = REQ_MAC;
    qry_valid = 1'b1; qry_ip = QRY_IP;
    @(negedge clk);
    req_valid = 1'b0; qry_valid = 1'b0;
    for (cyc = 0; cyc < 50; cyc++) begin
      if (tvalid === 1'b1) break;
      @(negedge clk);
    end
    n_checks++;
    if (cyc >= 50) $display("FAIL midreset_start: tvalid %b after %0d cycles, want 1", tvalid, cyc);
    else n_pass++;
    tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_valid = (i == 5);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || tdata !== 8'h00) $display("FAIL midreset_drop: tvalid %b busy %b tdata %h, want 0 0 00", tvalid, busy, tdata);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (tvalid === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) $display("FAIL midreset_slots: %0d active cycles after release, want 0", extra);
    else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    ip_local  = LOCAL_IP;
    mac_local = LOCAL_MAC;
    req_valid = 1'b0; req_ip = '0; req_mac = '0;
    qry_valid = 1'b0; qry_ip = '0;
    tready    = 1'b1;
    pulse_ip  = '0; pulse_mac = '0;
    @(negedge clk);
    test_reset();
    test_reply();
    test_query();
    test_back_to_back();
    test_random_ready();
    test_set_priority();
    test_overwrite();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
